// File: rtl/btn_debounce.sv
// Per-channel push-button / switch conditioner: input synchroniser, bounce-rejecting
// state machine with stability counter, debounced level and one-cycle press/release strobes.
module btn_debounce #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_s;
        state_t                 r_state;
        state_t                 w_state_next;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       w_cnt_next;
        logic                   w_press_next;
        logic                   w_release_next;
        logic                   w_level_next;
        logic                   r_level;
        logic                   r_press;
        logic                   r_release;

        assign w_s = r_sync[SYNC_STAGES-1];

        // Synchroniser chain; only its last flop reaches the FSM.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in[i]};
            end
        end

        // Next state, counter and strobe decode.
        always_comb begin
            w_state_next   = r_state;
            w_cnt_next     = r_cnt;
            w_press_next   = 1'b0;
            w_release_next = 1'b0;
            case (r_state)
                ST_LOW: begin
                    if (w_s) begin
                        w_state_next = ST_WAIT_HIGH;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_state_next = ST_LOW;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!w_s) begin
                        w_state_next = ST_LOW;
                        w_cnt_next   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = CNT_ZERO;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!w_s) begin
                        w_state_next = ST_WAIT_LOW;
                        w_cnt_next   = CNT_ZERO;
                    end else begin
                        w_state_next = ST_HIGH;
                    end
                end
                ST_WAIT_LOW: begin
                    if (w_s) begin
                        w_state_next = ST_HIGH;
                        w_cnt_next   = CNT_ZERO;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next   = ST_LOW;
                        w_cnt_next     = CNT_ZERO;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next     = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = CNT_ZERO;
                end
            endcase
        end

        // Level follows the state it is entering so both move on the same edge.
        assign w_level_next = (w_state_next == ST_HIGH) || (w_state_next == ST_WAIT_LOW);

        // State, counter and registered outputs; reset drops level without a release strobe.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_LOW;
                r_cnt     <= CNT_ZERO;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_next;
                r_cnt     <= w_cnt_next;
                r_level   <= w_level_next;
                r_press   <= w_press_next;
                r_release <= w_release_next;
            end
        end

        assign btn_level[i]   = r_level;
        assign btn_press[i]   = r_press;
        assign btn_release[i] = r_release;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Randomised and directed bench for btn_debounce against a run-length reference model
// (a change is accepted after DEBOUNCE_CYCLES+1 consecutive differing synchronised samples).
module tb_btn_debounce;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int D  = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    btn_debounce #(
        .N               (N),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [N-1:0] m_level;
    logic [N-1:0] m_press;
    logic [N-1:0] m_release;
    int           m_run [N];
    logic [N-1:0] in_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: input seen by the FSM is the pad value S edges earlier (0 right after reset).
    task automatic model_edge(input logic r, input logic [N-1:0] b);
        logic [N-1:0] s;
        if (r) begin
            m_level   = '0;
            m_press   = '0;
            m_release = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
            in_hist.delete();
        end else begin
            in_hist.push_front(b);
            s = (in_hist.size() > S) ? in_hist[S] : '0;
            if (in_hist.size() > S + 1) void'(in_hist.pop_back());
            m_press   = '0;
            m_release = '0;
            for (int c = 0; c < N; c++) begin
                if (s[c] != m_level[c]) m_run[c]++;
                else                    m_run[c] = 0;
                if (m_run[c] == D + 1) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) m_press[c]   = 1'b1;
                    else            m_release[c] = 1'b1;
                    m_run[c] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] b);
        @(negedge clk);
        rst    = r;
        btn_in = b;
        @(posedge clk);
        model_edge(r, b);
        #1;
        chk("level",   32'(btn_level),   32'(m_level));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_release));
        chk("excl",    32'(btn_press & btn_release), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rb;
        rst    = 1'b1;
        btn_in = '0;
        for (int c = 0; c < N; c++) m_run[c] = 0;
        m_level = '0; m_press = '0; m_release = '0;

        for (int k = 0; k < 3; k++) step(1'b1, 4'b0000);
        chk("reset_level", 32'(btn_level), 32'd0);

        // Clean press on channel 0: edge 0 is the first step.
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b0001);
            if (k == 5) chk("t1_level_pre", 32'(btn_level), 32'd0);
            if (k == 6) chk("t1_press",     32'(btn_press), 32'd1);
            if (k == 7) chk("t1_press_end", 32'(btn_press), 32'd0);
        end

        // Release on channel 0.
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b0000);
            if (k == 6) chk("t4_release", 32'(btn_release), 32'd1);
            if (k == 6) chk("t4_level",   32'(btn_level),   32'd0);
        end

        // Bounce on channel 1, then held high.
        step(1'b0, 4'b0010); step(1'b0, 4'b0000);
        step(1'b0, 4'b0010); step(1'b0, 4'b0000);
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b0010);
            if (k == 6) chk("t2_press", 32'(btn_press), 32'd2);
        end
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0000);

        // Short glitch on channel 2.
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0100);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 4'b0000);
            chk("t3_level", 32'(btn_level[2]), 32'd0);
        end

        // Reset mid-count on channel 3, then reset while channel 0 is high.
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0001);
        for (int k = 0; k < 5; k++) step(1'b0, 4'b1001);
        step(1'b1, 4'b1001);
        chk("t5_rst_out", 32'({btn_level, btn_press, btn_release}), 32'd0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 4'b1001);
            if (k == 6) chk("t5_repress", 32'(btn_press), 32'h9);
        end
        step(1'b1, 4'b1001);
        chk("t5_rst_hi", 32'({btn_level, btn_release}), 32'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 4'b0000);

        // Simultaneous press and release on all channels.
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b1111);
            if (k == 6) chk("t6_press", 32'(btn_press), 32'hF);
        end
        for (int k = 0; k <= 9; k++) begin
            step(1'b0, 4'b0000);
            if (k == 6) chk("t6_release", 32'(btn_release), 32'hF);
        end

        // Random bounce, holds and occasional reset.
        rb = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
            step(($urandom_range(0, 149) == 0), rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
